// File: rtl/usb_line_pkg.sv
// Shared types and constants for the full-speed USB transmit line stage.
package usb_line_pkg;

  localparam int unsigned BIT_CNT_W = 11;
  localparam int unsigned PHASE_CNT_W = 8;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 11'h7FF;
  localparam logic [2:0] STUFF_LIMIT = 3'd7;

  // Line state packed as {D+, D-}
  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_GAP
  } tx_state_e;

  function automatic line_t nrzi_line(input logic is_j);
    return is_j ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_tx_line_if.sv
// Serializer-side bit stream in, transceiver line and status out.
interface usb_tx_line_if;
  import usb_line_pkg::*;

  logic                 checkData;
  logic                 txBit;
  logic                 txOE;
  logic                 txEop;
  logic                 usbDp;
  logic                 usbDn;
  logic                 usbOE;
  logic                 txBusy;
  logic                 txDone;
  logic                 txAbort;
  logic                 stuffErr;
  logic [BIT_CNT_W-1:0] bitCount;

  modport master (
    output checkData, txBit, txOE, txEop,
    input  usbDp, usbDn, usbOE, txBusy, txDone, txAbort, stuffErr, bitCount
  );

  modport slave (
    input  checkData, txBit, txOE, txEop,
    output usbDp, usbDn, usbOE, txBusy, txDone, txAbort, stuffErr, bitCount
  );

endinterface

// File: rtl/usb_stuff_monitor.sv
// Counts consecutive 1s in the outgoing NRZ stream; sticky flag on a run of seven.
module usb_stuff_monitor
  import usb_line_pkg::*;
(
  input  logic useClk,
  input  logic Reset,
  input  logic enable_i,
  input  logic first_i,
  input  logic bit_i,
  output logic err_o
);

  logic [2:0] ones_q;
  logic [2:0] ones_d;
  logic       err_q;

  // First bit of a packet restarts the run regardless of history
  always_comb begin
    ones_d = ones_q;
    if (!bit_i) begin
      ones_d = 3'd0;
    end else if (first_i) begin
      ones_d = 3'd1;
    end else if (ones_q != STUFF_LIMIT) begin
      ones_d = ones_q + 3'd1;
    end
  end

  always_ff @(posedge useClk) begin
    if (Reset) begin
      ones_q <= 3'd0;
      err_q  <= 1'b0;
    end else if (enable_i) begin
      ones_q <= ones_d;
      if (ones_d == STUFF_LIMIT) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/usb_tx_line.sv
// NRZI line driver with SE0-SE0-J end of packet, inter-packet gap and length count.
module usb_tx_line
  import usb_line_pkg::*;
#(
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned GAP_BITS     = 2
) (
  input  logic          useClk,
  input  logic          Reset,
  usb_tx_line_if.slave  bus
);

  tx_state_e              state_q;
  line_t                  line_q;
  logic                   nrzi_j_q;
  logic                   nrzi_j_d;
  logic                   oe_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   abort_q;
  logic                   eop_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_d;
  logic [PHASE_CNT_W-1:0] phase_q;
  logic                   start_pkt;
  logic                   send_bit;
  logic                   stuff_err;

  always_comb begin
    nrzi_j_d  = bus.txBit ? nrzi_j_q : ~nrzi_j_q;
    bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? bit_cnt_q : bit_cnt_q + BIT_CNT_W'(1);
    start_pkt = bus.checkData && (state_q == ST_IDLE) && bus.txOE;
    send_bit  = bus.checkData && (state_q == ST_ACTIVE) && !eop_q
                && (bus.txOE || bus.txEop);
  end

  usb_stuff_monitor u_stuff (
    .useClk   (useClk),
    .Reset    (Reset),
    .enable_i (start_pkt || send_bit),
    .first_i  (start_pkt),
    .bit_i    (bus.txBit),
    .err_o    (stuff_err)
  );

  // state_q names what the line is currently driving; eop_q marks the last data bit
  always_ff @(posedge useClk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      line_q    <= LINE_J;
      nrzi_j_q  <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      eop_q     <= 1'b0;
      bit_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (bus.checkData) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.txOE) begin
              state_q   <= ST_ACTIVE;
              line_q    <= nrzi_line(nrzi_j_d);
              nrzi_j_q  <= nrzi_j_d;
              oe_q      <= 1'b1;
              busy_q    <= 1'b1;
              eop_q     <= 1'b0;
              bit_cnt_q <= BIT_CNT_W'(1);
            end
          end
          ST_ACTIVE: begin
            if (eop_q) begin
              state_q <= ST_EOP_SE0;
              line_q  <= LINE_SE0;
              eop_q   <= 1'b0;
              phase_q <= PHASE_CNT_W'(1);
            end else if (bus.txOE || bus.txEop) begin
              line_q    <= nrzi_line(nrzi_j_d);
              nrzi_j_q  <= nrzi_j_d;
              bit_cnt_q <= bit_cnt_d;
              eop_q     <= bus.txEop;
            end else begin
              // Serializer dropped OE mid-packet: close the line with an EOP now
              state_q <= ST_EOP_SE0;
              line_q  <= LINE_SE0;
              abort_q <= 1'b1;
              phase_q <= PHASE_CNT_W'(1);
            end
          end
          ST_EOP_SE0: begin
            if (phase_q == PHASE_CNT_W'(EOP_SE0_BITS)) begin
              state_q <= ST_EOP_J;
              line_q  <= LINE_J;
            end else begin
              phase_q <= phase_q + PHASE_CNT_W'(1);
            end
          end
          ST_EOP_J: begin
            state_q  <= ST_GAP;
            line_q   <= LINE_J;
            nrzi_j_q <= 1'b1;
            oe_q     <= 1'b0;
            done_q   <= 1'b1;
            phase_q  <= '0;
          end
          ST_GAP: begin
            if (phase_q == PHASE_CNT_W'(GAP_BITS - 1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              phase_q <= phase_q + PHASE_CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.usbDp    = line_q[1];
  assign bus.usbDn    = line_q[0];
  assign bus.usbOE    = oe_q;
  assign bus.txBusy   = busy_q;
  assign bus.txDone   = done_q;
  assign bus.txAbort  = abort_q;
  assign bus.stuffErr = stuff_err;
  assign bus.bitCount = bit_cnt_q;

endmodule
